// File: rtl/div_iterative_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU, with shared op/state types.
// Define DIV_EARLY_EXIT_EN to skip the iteration loop for trivially resolved divisions.

package div_iterative_unit_pkg;

  // One-hot decoded operation word; only the divider ops matter here.
  typedef enum logic [52:0] {
    OP_NONE = 53'h0,
    ADD     = 53'h1,
    SUB     = 53'h1 << 1,
    MUL     = 53'h1 << 45,
    DIV     = 53'h1 << 49,
    DIVU    = 53'h1 << 50,
    REM     = 53'h1 << 51,
    REMU    = 53'h1 << 52
  } iType_e;

  typedef enum logic [1:0] {
    D_IDLE,
    D_INIT,
    D_CALC,
    D_SIGN
  } div_states_e;

endpackage

module div_iterative_unit
  import div_iterative_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start_i,
  input  logic            flush_i,
  input  logic [52:0]     operation_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES = '1;

  div_states_e     state;
  logic [XLEN-1:0] dividend_q;
  logic [XLEN-1:0] divisor_q;
  logic [XLEN-1:0] divisor_mag_q;
  logic [XLEN-1:0] quot_q;
  logic [XLEN-1:0] rem_q;
  logic [CW-1:0]   count_q;
  logic            signed_q;
  logic            is_rem_q;
  logic            result_neg_q;
  logic            div_by_zero_q;
  logic            overflow_q;

  logic            is_div_op;
  logic            is_signed_op;
  logic            is_rem_op;
  logic [XLEN-1:0] dividend_abs;
  logic [XLEN-1:0] divisor_abs;
  logic            div_by_zero_now;
  logic            overflow_now;
  logic [XLEN:0]   rem_shift;
  logic [XLEN:0]   trial_diff;
  logic [XLEN-1:0] magnitude;
  logic [XLEN-1:0] final_value;

  assign is_signed_op = (operation_i == DIV) || (operation_i == REM);
  assign is_rem_op    = (operation_i == REM) || (operation_i == REMU);
  assign is_div_op    = is_signed_op || (operation_i == DIVU) || (operation_i == REMU);

  assign dividend_abs    = (signed_q && dividend_q[XLEN-1]) ? -dividend_q : dividend_q;
  assign divisor_abs     = (signed_q && divisor_q[XLEN-1])  ? -divisor_q  : divisor_q;
  assign div_by_zero_now = (divisor_q == '0);
  assign overflow_now    = signed_q && (dividend_q == MOST_NEG) && (divisor_q == ALL_ONES);

  // The 33-bit trial subtract: a clear MSB means the divisor fits into the partial remainder.
  assign rem_shift  = {rem_q, quot_q[XLEN-1]};
  assign trial_diff = rem_shift - {1'b0, divisor_mag_q};

  always_comb begin
    magnitude   = is_rem_q ? rem_q : quot_q;
    final_value = result_neg_q ? -magnitude : magnitude;
    if (div_by_zero_q) begin
      final_value = is_rem_q ? dividend_q : ALL_ONES;
    end else if (overflow_q) begin
      final_value = is_rem_q ? '0 : MOST_NEG;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= D_IDLE;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      result_o      <= '0;
      dividend_q    <= '0;
      divisor_q     <= '0;
      divisor_mag_q <= '0;
      quot_q        <= '0;
      rem_q         <= '0;
      count_q       <= '0;
      signed_q      <= 1'b0;
      is_rem_q      <= 1'b0;
      result_neg_q  <= 1'b0;
      div_by_zero_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      done_o <= 1'b0;
      unique case (state)
        D_IDLE: begin
          if (start_i && !flush_i && is_div_op) begin
            dividend_q   <= rs1_data_i;
            divisor_q    <= rs2_data_i;
            signed_q     <= is_signed_op;
            is_rem_q     <= is_rem_op;
            result_neg_q <= is_signed_op &&
                            (is_rem_op ? rs1_data_i[XLEN-1]
                                       : (rs1_data_i[XLEN-1] ^ rs2_data_i[XLEN-1]));
            state        <= D_INIT;
            busy_o       <= 1'b1;
          end
        end

        D_INIT: begin
          if (flush_i) begin
            state  <= D_IDLE;
            busy_o <= 1'b0;
          end else begin
            quot_q        <= dividend_abs;
            rem_q         <= '0;
            divisor_mag_q <= divisor_abs;
            count_q       <= CW'(XLEN - 1);
            div_by_zero_q <= div_by_zero_now;
            overflow_q    <= overflow_now;
`ifdef DIV_EARLY_EXIT_EN
            // Results already known: quotient 0 and remainder |rs1| recover rs1 after sign fix-up.
            if (div_by_zero_now || overflow_now || (dividend_abs < divisor_abs)) begin
              quot_q <= '0;
              rem_q  <= dividend_abs;
              state  <= D_SIGN;
            end else begin
              state  <= D_CALC;
            end
`else
            state <= D_CALC;
`endif
          end
        end

        D_CALC: begin
          if (flush_i) begin
            state  <= D_IDLE;
            busy_o <= 1'b0;
          end else begin
            if (!trial_diff[XLEN]) begin
              rem_q  <= trial_diff[XLEN-1:0];
              quot_q <= {quot_q[XLEN-2:0], 1'b1};
            end else begin
              rem_q  <= rem_shift[XLEN-1:0];
              quot_q <= {quot_q[XLEN-2:0], 1'b0};
            end
            if (count_q == '0) begin
              state <= D_SIGN;
            end else begin
              count_q <= count_q - 1'b1;
            end
          end
        end

        D_SIGN: begin
          state  <= D_IDLE;
          busy_o <= 1'b0;
          if (!flush_i) begin
            result_o <= final_value;
            done_o   <= 1'b1;
          end
        end

        default: begin
          state  <= D_IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_iterative_unit.sv
// Directed self-checking bench for div_iterative_unit: results, latency, flush, reset, ignored starts.
// Honours DIV_EARLY_EXIT_EN when computing the expected latency of trivially resolved divisions.

module tb_div_iterative_unit;
  import div_iterative_unit_pkg::*;

  localparam int FULL_LAT = 35;
`ifdef DIV_EARLY_EXIT_EN
  localparam int EARLY_LAT = 3;
`else
  localparam int EARLY_LAT = 35;
`endif
  localparam int TIMEOUT = 100;

  logic        clk;
  logic        reset_n;
  logic        start_i;
  logic        flush_i;
  logic [52:0] operation_i;
  logic [31:0] rs1_data_i;
  logic [31:0] rs2_data_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;

  int checks;
  int passed;

  div_iterative_unit #(.XLEN(32)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start_i    (start_i),
    .flush_i    (flush_i),
    .operation_i(operation_i),
    .rs1_data_i (rs1_data_i),
    .rs2_data_i (rs2_data_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .result_o   (result_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Launch one operation and observe it; the start edge counts as edge 1.
  task automatic run_op(input logic [52:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat,
                        output logic busy_held, output logic done_after);
    @(negedge clk);
    start_i = 1'b1; operation_i = op; rs1_data_i = a; rs2_data_i = b;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    start_i = 1'b0; operation_i = '0; rs1_data_i = '0; rs2_data_i = '0;
    busy_held = 1'b1;
    while (done_o !== 1'b1 && lat < TIMEOUT) begin
      if (busy_o !== 1'b1) busy_held = 1'b0;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    res = result_o;
    @(posedge clk);
    @(negedge clk);
    done_after = done_o;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start_i = 1'b0; flush_i = 1'b0;
    operation_i = '0; rs1_data_i = '0; rs2_data_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy_o, done_o, result_o} !== 34'h0)
      $display("[TB] FAIL reset_state: busy=%b done=%b result=%h expected 0/0/0", busy_o, done_o, result_o);
    else passed++;
    reset_n = 1'b1;
  endtask

  task automatic test_vectors(input string tag, input int n,
                              input logic [52:0] ops [8], input logic [31:0] a_v [8],
                              input logic [31:0] b_v [8], input logic [31:0] exp_v [8],
                              input int lat_v [8]);
    logic [31:0] res;
    int          lat;
    logic        bh, da;
    for (int i = 0; i < n; i++) begin
      run_op(ops[i], a_v[i], b_v[i], res, lat, bh, da);
      checks++;
      if (res !== exp_v[i])
        $display("[TB] FAIL %s[%0d] result: got %h expected %h", tag, i, res, exp_v[i]);
      else passed++;
      checks++;
      if (lat !== lat_v[i])
        $display("[TB] FAIL %s[%0d] latency: got %0d edges expected %0d", tag, i, lat, lat_v[i]);
      else passed++;
      checks++;
      if (bh !== 1'b1)
        $display("[TB] FAIL %s[%0d] busy_held: got %b expected 1", tag, i, bh);
      else passed++;
      checks++;
      if (da !== 1'b0)
        $display("[TB] FAIL %s[%0d] done_pulse_width: done still %b expected 0", tag, i, da);
      else passed++;
    end
  endtask

  task automatic test_unsigned();
    logic [52:0] ops [8];
    logic [31:0] a_v [8], b_v [8], e_v [8];
    int          l_v [8];
    ops = '{DIVU, REMU, DIVU, REMU, DIVU, DIVU, DIVU, DIVU};
    a_v = '{32'd100, 32'd100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, 0};
    b_v = '{32'd7, 32'd7, 32'd16, 32'd16, 0, 0, 0, 0};
    e_v = '{32'd14, 32'd2, 32'h0FFF_FFFF, 32'd15, 0, 0, 0, 0};
    l_v = '{FULL_LAT, FULL_LAT, FULL_LAT, FULL_LAT, 0, 0, 0, 0};
    test_vectors("unsigned", 4, ops, a_v, b_v, e_v, l_v);
  endtask

  task automatic test_signed();
    logic [52:0] ops [8];
    logic [31:0] a_v [8], b_v [8], e_v [8];
    int          l_v [8];
    ops = '{REM, DIV, DIV, REM, DIV, DIVU, DIVU, DIVU};
    a_v = '{-32'sd7, -32'sd7, 32'd7, 32'd7, -32'sd100, 0, 0, 0};
    b_v = '{32'd2, 32'd2, -32'sd2, -32'sd2, -32'sd7, 0, 0, 0};
    e_v = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'd1, 32'd14, 0, 0, 0};
    l_v = '{FULL_LAT, FULL_LAT, FULL_LAT, FULL_LAT, FULL_LAT, 0, 0, 0};
    test_vectors("signed", 5, ops, a_v, b_v, e_v, l_v);
  endtask

  task automatic test_overflow();
    logic [52:0] ops [8];
    logic [31:0] a_v [8], b_v [8], e_v [8];
    int          l_v [8];
    ops = '{DIV, REM, DIVU, DIVU, DIVU, DIVU, DIVU, DIVU};
    a_v = '{32'h8000_0000, 32'h8000_0000, 0, 0, 0, 0, 0, 0};
    b_v = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0};
    e_v = '{32'h8000_0000, 32'h0, 0, 0, 0, 0, 0, 0};
    l_v = '{EARLY_LAT, EARLY_LAT, 0, 0, 0, 0, 0, 0};
    test_vectors("overflow", 2, ops, a_v, b_v, e_v, l_v);
  endtask

  task automatic test_div_by_zero();
    logic [52:0] ops [8];
    logic [31:0] a_v [8], b_v [8], e_v [8];
    int          l_v [8];
    ops = '{DIVU, REMU, DIV, REM, DIVU, DIVU, DIVU, DIVU};
    a_v = '{32'd5, 32'd5, -32'sd20, -32'sd20, 0, 0, 0, 0};
    b_v = '{0, 0, 0, 0, 0, 0, 0, 0};
    e_v = '{32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFEC, 0, 0, 0, 0};
    l_v = '{EARLY_LAT, EARLY_LAT, EARLY_LAT, EARLY_LAT, 0, 0, 0, 0};
    test_vectors("div_by_zero", 4, ops, a_v, b_v, e_v, l_v);
  endtask

  task automatic test_flush(input logic [31:0] prev);
    logic [31:0] res;
    int          lat;
    logic        bh, da, saw_done;
    @(negedge clk);
    start_i = 1'b1; operation_i = DIVU; rs1_data_i = 32'd1000; rs2_data_i = 32'd3;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    repeat (11) @(posedge clk);
    @(negedge clk);
    flush_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush_i = 1'b0;
    checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0)
      $display("[TB] FAIL flush_calc: busy=%b done=%b expected 0/0", busy_o, done_o);
    else passed++;

    // A start that coincides with a flush in idle must be dropped.
    start_i = 1'b1; flush_i = 1'b1; operation_i = DIVU; rs1_data_i = 32'd50; rs2_data_i = 32'd5;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0; flush_i = 1'b0;
    checks++;
    if (busy_o !== 1'b0)
      $display("[TB] FAIL flush_start_drop: busy=%b expected 0", busy_o);
    else passed++;

    saw_done = 1'b0;
    repeat (40) begin
      @(posedge clk);
      @(negedge clk);
      if (done_o === 1'b1) saw_done = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0)
      $display("[TB] FAIL flush_no_done: saw done=%b expected 0", saw_done);
    else passed++;
    checks++;
    if (result_o !== prev)
      $display("[TB] FAIL flush_result_hold: got %h expected %h", result_o, prev);
    else passed++;

    run_op(DIVU, 32'd9, 32'd3, res, lat, bh, da);
    checks++;
    if (res !== 32'd3)
      $display("[TB] FAIL after_flush_result: got %h expected %h", res, 32'd3);
    else passed++;
    checks++;
    if (lat !== FULL_LAT)
      $display("[TB] FAIL after_flush_latency: got %0d expected %0d", lat, FULL_LAT);
    else passed++;
  endtask

  task automatic test_busy_ignore();
    int   lat;
    logic saw_extra;
    @(negedge clk);
    start_i = 1'b1; operation_i = DIVU; rs1_data_i = 32'd9; rs2_data_i = 32'd3;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (4) begin @(posedge clk); lat++; end
    @(negedge clk);
    start_i = 1'b1; operation_i = DIVU; rs1_data_i = 32'd50; rs2_data_i = 32'd5;
    @(posedge clk);
    lat++;
    @(negedge clk);
    start_i = 1'b0; operation_i = '0; rs1_data_i = '0; rs2_data_i = '0;
    while (done_o !== 1'b1 && lat < TIMEOUT) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    checks++;
    if (result_o !== 32'd3)
      $display("[TB] FAIL busy_ignore_result: got %h expected %h", result_o, 32'd3);
    else passed++;
    checks++;
    if (lat !== FULL_LAT)
      $display("[TB] FAIL busy_ignore_latency: got %0d expected %0d", lat, FULL_LAT);
    else passed++;
    saw_extra = 1'b0;
    repeat (40) begin
      @(posedge clk);
      @(negedge clk);
      if (done_o === 1'b1 || busy_o === 1'b1) saw_extra = 1'b1;
    end
    checks++;
    if (saw_extra !== 1'b0 || result_o !== 32'd3)
      $display("[TB] FAIL busy_ignore_no_rerun: activity=%b result=%h expected 0/%h",
               saw_extra, result_o, 32'd3);
    else passed++;
  endtask

  task automatic test_ignore_other();
    logic saw_done;
    @(negedge clk);
    start_i = 1'b1; operation_i = MUL; rs1_data_i = 32'd6; rs2_data_i = 32'd3;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0; operation_i = '0;
    checks++;
    if (busy_o !== 1'b0)
      $display("[TB] FAIL ignore_other_busy: busy=%b expected 0", busy_o);
    else passed++;
    saw_done = 1'b0;
    repeat (40) begin
      @(posedge clk);
      @(negedge clk);
      if (done_o === 1'b1) saw_done = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0 || result_o !== 32'd0)
      $display("[TB] FAIL ignore_other_no_done: done_seen=%b result=%h expected 0/%h",
               saw_done, result_o, 32'd0);
    else passed++;
  endtask

  task automatic test_early_exit();
    logic [52:0] ops [8];
    logic [31:0] a_v [8], b_v [8], e_v [8];
    int          l_v [8];
    ops = '{DIVU, REM, DIV, DIVU, DIVU, DIVU, DIVU, DIVU};
    a_v = '{32'd3, -32'sd3, 32'd5, 0, 0, 0, 0, 0};
    b_v = '{32'd10, 32'd10, -32'sd6, 0, 0, 0, 0, 0};
    e_v = '{32'd0, 32'hFFFF_FFFD, 32'd0, 0, 0, 0, 0, 0};
    l_v = '{EARLY_LAT, EARLY_LAT, EARLY_LAT, 0, 0, 0, 0, 0};
    test_vectors("early_exit", 3, ops, a_v, b_v, e_v, l_v);
  endtask

  task automatic test_reset_mid_calc();
    logic [31:0] res;
    int          lat;
    logic        bh, da;
    run_op(DIVU, 32'd100, 32'd7, res, lat, bh, da);
    checks++;
    if (res !== 32'd14)
      $display("[TB] FAIL pre_reset_result: got %h expected %h", res, 32'd14);
    else passed++;
    @(negedge clk);
    start_i = 1'b1; operation_i = DIVU; rs1_data_i = 32'd1000; rs2_data_i = 32'd3;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy_o, done_o, result_o} !== 34'h0)
      $display("[TB] FAIL reset_mid_calc: busy=%b done=%b result=%h expected 0/0/0",
               busy_o, done_o, result_o);
    else passed++;
    reset_n = 1'b1;
    run_op(DIV, -32'sd100, 32'd7, res, lat, bh, da);
    checks++;
    if (res !== 32'hFFFF_FFF2)
      $display("[TB] FAIL post_reset_result: got %h expected %h", res, 32'hFFFF_FFF2);
    else passed++;
  endtask

  initial begin
    checks = 0;
    passed = 0;
    test_reset();
    test_unsigned();
    test_signed();
    test_overflow();
    test_div_by_zero();
    test_flush(32'hFFFF_FFEC);
    test_busy_ignore();
    test_early_exit();
    test_ignore_other();
    test_reset_mid_calc();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/div_iterative_unit.md
Name: div_iterative_unit

Overview:
- Iterative 32-bit radix-2 restoring divider for the M-extension ops DIV, DIVU, REM and REMU.
- Sits in the execute stage next to the ALU. Consumes the decoded iType_e operation and both operand values from decode.
- Stalls the pipeline via busy_o until the result is ready.
- Sequenced by the package's div_states_e FSM: D_IDLE, D_INIT, D_CALC, D_SIGN.

Parameters:
- XLEN, 32, operand and result width. Only 32 is supported; the iteration counter is $clog2(XLEN) bits.

Ports:
- clk  input  1  core clock
- reset_n  input  1  synchronous active-low reset, sampled on rising clk
- start_i  input  1  request a division this cycle
- flush_i  input  1  abort the in-flight operation (pipeline flush or trap)
- operation_i  input  53  iType_e decoded operation
- rs1_data_i  input  XLEN  dividend
- rs2_data_i  input  XLEN  divisor
- busy_o  output  1  operation in progress; the pipeline must hold
- done_o  output  1  one-cycle pulse; result_o is valid
- result_o  output  XLEN  quotient (DIV/DIVU) or remainder (REM/REMU)

Behaviour:
- Reset (reset_n=0 at a rising edge): state=D_IDLE, busy_o=0, done_o=0, result_o=0, all internal registers cleared. This holds even mid-operation.
- Accept: start_i=1 in D_IDLE with operation_i in {DIV, DIVU, REM, REMU}.
  - The unit latches the operands, signed flag (DIV/REM), remainder flag (REM/REMU) and target sign.
  - Next state is D_INIT; busy_o goes to 1 from the next cycle.
- Other operations: start_i with any other operation_i is ignored.
- start_i while busy_o=1: ignored. Operands are never re-latched mid-operation.
- D_INIT (1 cycle):
  - Computes absolute values when signed; otherwise passes operands through.
  - Quotient register = |dividend|, partial remainder = 0, counter = XLEN-1.
  - Flags div_by_zero (rs2==0) and overflow (signed, rs1==0x80000000, rs2==0xFFFFFFFF).
  - Next state D_CALC.
- D_CALC (XLEN cycles):
  - Each cycle shifts {rem,quot} left by 1.
  - Trial-subtracts the divisor magnitude (XLEN+1 bit subtract). If non-negative, keeps the difference and sets the quotient LSB to 1.
  - Counter decrements. When counter==0 at the edge, next state is D_SIGN.
- D_SIGN (1 cycle): registers the final value into result_o, pulses done_o, next state D_IDLE, busy_o=0 the following cycle. Final value:
  - div_by_zero: quotient=0xFFFFFFFF, remainder=rs1 (signed and unsigned alike).
  - overflow: quotient=0x80000000, remainder=0.
  - Otherwise, signed ops: quotient negated if the operand signs differ; remainder takes the dividend's sign.
- Latency: done_o is high in the cycle after the 35th rising edge counted from the edge that sampled start_i (INIT 1 + CALC 32 + SIGN 1 + register).
- done_o is high for exactly one cycle. result_o holds its value until the next done_o or reset.
- flush_i=1 in any non-IDLE state: next state D_IDLE, no done_o, result_o unchanged.
- flush_i together with start_i in D_IDLE: the start is dropped.
- Reset has priority over flush_i; flush_i has priority over state progress.
- busy_o is registered, equal to (state != D_IDLE).

Optional Feature:
- Macro: DIV_EARLY_EXIT_EN.
- Defined: in D_INIT, if div_by_zero, overflow, or (no flag and |rs1| < |rs2| as unsigned magnitudes), the unit skips D_CALC and goes straight to D_SIGN.
  - Results are as specified above; for the |rs1|<|rs2| case, quotient=0 and remainder=rs1.
  - done_o then follows 3 edges after the start edge.
- Undefined: every accepted operation takes the full 35-edge latency. Results are identical in both builds.

Test Plan:
- DIVU 100/7 -> result_o=14 after 35 edges, done_o one cycle. Repeat as REMU -> 2. busy_o high throughout.
- REM -7/2 -> 0xFFFFFFFF (-1); DIV -7/2 -> 0xFFFFFFFD (-3); DIV 7/-2 -> 0xFFFFFFFD.
- DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0.
- DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV -20/0 -> 0xFFFFFFFF; REM -20/0 -> 0xFFFFFFEC.
- Start DIVU 1000/3, assert flush_i at CALC cycle 10 -> no done_o, busy_o=0 next cycle. A new DIVU 9/3 then yields 3. A start_i pulse during busy with 50/5 is ignored (result stays 3).
- Reset mid-CALC -> result_o=0, done_o=0, busy_o=0. With DIV_EARLY_EXIT_EN, DIVU 3/10 -> 0 with done_o 3 edges after start.
